// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline-side hazard inputs, and the stall/flush,
// forwarding and performance-counter outputs returned to the core.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D, rs2D;
  logic [4:0]       rs1E, rs2E, rdE;
  logic [1:0]       result_srcE;
  logic             pc_srcE;
  logic [4:0]       rdM, rdW;
  logic             reg_writeM, reg_writeW;
  logic             mem_reqM;
  logic             mem_ready;
  logic [1:0]       forward_aE, forward_bE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, result_srcE, pc_srcE,
           rdM, rdW, reg_writeM, reg_writeW, mem_reqM, mem_ready,
    input  forward_aE, forward_bE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout,
           lu_stall_cnt, flush_cnt, mem_wait_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, result_srcE, pc_srcE,
           rdM, rdW, reg_writeM, reg_writeW, mem_reqM, mem_ready,
    output forward_aE, forward_bE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_timeout,
           lu_stall_cnt, flush_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage RISC-V hazard controller: forwarding selects, stall/flush strobes,
// memory-wait FSM with sticky watchdog, and hazard performance counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic    clk,
  input  logic    reset,
  hazard_if.slave hz
);
  localparam int WC_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [WC_W-1:0]  wait_cycles, wait_inc;
  logic             timeout_q;
  logic [CNT_W-1:0] lu_cnt, fl_cnt, mw_cnt;
  logic             lu, mw;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic [4:0] rd_m, input logic wr_m,
    input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign lu = (hz.result_srcE == 2'b01) && (hz.rdE != 5'd0) &&
              ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
  assign mw = hz.mem_reqM && !hz.mem_ready;
  assign wait_inc = sat_inc(wait_cycles);

  // Strobes: memory wait freezes everything and never flushes a frozen stage
  always_comb begin
    hz.forward_aE = 2'b00;
    hz.forward_bE = 2'b00;
    hz.StallF     = 1'b0;
    hz.StallD     = 1'b0;
    hz.StallE     = 1'b0;
    hz.StallM     = 1'b0;
    hz.FlushD     = 1'b0;
    hz.FlushE     = 1'b0;
    hz.FlushW     = 1'b0;
    if (reset) begin
      hz.forward_aE = fwd_sel(hz.rs1E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);
      hz.forward_bE = fwd_sel(hz.rs2E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);
      if (mw) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else if (hz.pc_srcE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lu) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mw) state_nxt = WAIT;
      WAIT:    if (hz.mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog and counters; timeout only reports, it never releases the stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cycles <= '0;
      timeout_q   <= 1'b0;
      lu_cnt      <= '0;
      fl_cnt      <= '0;
      mw_cnt      <= '0;
    end else begin
      if (state == IDLE) begin
        if (mw) wait_cycles <= '0;
      end else begin
        wait_cycles <= wait_inc;
        if (wait_inc >= TIMEOUT_V) timeout_q <= 1'b1;
      end
      if (lu && !hz.pc_srcE && !mw) lu_cnt <= lu_cnt + CNT_W'(1);
      if (hz.pc_srcE && !mw)        fl_cnt <= fl_cnt + CNT_W'(1);
      if (mw)                       mw_cnt <= mw_cnt + CNT_W'(1);
    end
  end

  assign hz.mem_timeout  = timeout_q;
  assign hz.lu_stall_cnt = lu_cnt;
  assign hz.flush_cnt    = fl_cnt;
  assign hz.mem_wait_cnt = mw_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors, a rule-level reference model checked
// every cycle, and literal expectations at key points of each scenario.
module tb_hazard_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  hazard_if #(.CNT_W(32)) hz ();

  hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: wait tracking as "are we inside a memory wait, for how long"
  bit          m_in_wait;
  int          m_wait_len;
  bit          m_to;
  logic [31:0] m_lu, m_fl, m_mw;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hz.reg_writeM && hz.rdM != 0 && hz.rdM == rs) return 2'b10;
    if (hz.reg_writeW && hz.rdW != 0 && hz.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu_now();
    return hz.result_srcE == 2'b01 && hz.rdE != 0 &&
           (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
  endfunction

  always @(posedge clk) begin
    bit mwait;
    mwait = hz.mem_reqM && !hz.mem_ready;
    if (!reset) begin
      m_in_wait = 0; m_wait_len = 0; m_to = 0;
      m_lu = 0; m_fl = 0; m_mw = 0;
    end else begin
      if (mwait) m_mw = m_mw + 1;
      if (hz.pc_srcE && !mwait) m_fl = m_fl + 1;
      if (m_lu_now() && !hz.pc_srcE && !mwait) m_lu = m_lu + 1;
      if (m_in_wait) begin
        m_wait_len = (m_wait_len < 255) ? m_wait_len + 1 : 255;
        if (m_wait_len >= TO) m_to = 1;
        if (hz.mem_ready) m_in_wait = 0;
      end else if (mwait) begin
        m_in_wait = 1;
        m_wait_len = 0;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    logic [6:0] exp_s;
    logic [1:0] ea, eb;
    bit mwait;
    if (chk_en) begin
      mwait = hz.mem_reqM && !hz.mem_ready;
      exp_s = 7'b0; ea = 2'b00; eb = 2'b00;
      if (reset) begin
        ea = m_fwd(hz.rs1E);
        eb = m_fwd(hz.rs2E);
        if (mwait)            exp_s = 7'b1111_001;
        else if (hz.pc_srcE)  exp_s = 7'b0000_110;
        else if (m_lu_now())  exp_s = 7'b1100_010;
      end
      check("model_fwd_a", 32'(hz.forward_aE), 32'(ea));
      check("model_fwd_b", 32'(hz.forward_bE), 32'(eb));
      check("model_strobes {SF,SD,SE,SM,FD,FE,FW}",
            32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW}),
            32'(exp_s));
      check("model_timeout", 32'(hz.mem_timeout), 32'(m_to));
      check("model_lu_cnt", hz.lu_stall_cnt, m_lu);
      check("model_flush_cnt", hz.flush_cnt, m_fl);
      check("model_mw_cnt", hz.mem_wait_cnt, m_mw);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.rs1D = 0; hz.rs2D = 0; hz.rs1E = 0; hz.rs2E = 0; hz.rdE = 0;
    hz.result_srcE = 0; hz.pc_srcE = 0; hz.rdM = 0; hz.rdW = 0;
    hz.reg_writeM = 0; hz.reg_writeW = 0; hz.mem_reqM = 0; hz.mem_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_in();
    reset = 1'b0;
    cyc();
    // Outputs forced low while reset is held, even with hazards present
    cyc();
    hz.pc_srcE = 1; hz.rs1E = 5; hz.rdM = 5; hz.reg_writeM = 1;
    hz.mem_reqM = 1;
    #1;
    check("reset_flushD", 32'(hz.FlushD), 0);
    check("reset_stallF", 32'(hz.StallF), 0);
    check("reset_fwd_a", 32'(hz.forward_aE), 0);
    check("reset_cnts", hz.lu_stall_cnt | hz.flush_cnt | hz.mem_wait_cnt, 0);
    check("reset_timeout", 32'(hz.mem_timeout), 0);
    cyc();
    clear_in();
    reset = 1'b1;

    // Forwarding
    cyc();
    hz.rs1E = 5; hz.rdM = 5; hz.reg_writeM = 1; hz.rdW = 5; hz.reg_writeW = 1;
    #1 check("fwd_mem_wins", 32'(hz.forward_aE), 32'h2);
    cyc();
    hz.reg_writeM = 0;
    hz.rs2E = 5;
    #1 check("fwd_wb", 32'(hz.forward_aE), 32'h1);
    check("fwd_b_wb", 32'(hz.forward_bE), 32'h1);
    cyc();
    hz.rdM = 0; hz.rdW = 0; hz.rs1E = 0; hz.reg_writeM = 1;
    #1 check("fwd_x0", 32'(hz.forward_aE), 32'h0);
    cyc();
    clear_in();

    // Load-use: one bubble
    hz.result_srcE = 2'b01; hz.rdE = 7; hz.rs2D = 7;
    #1 check("lu_strobes", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'h7);
    cyc();
    clear_in();
    #1 check("lu_cnt_1", hz.lu_stall_cnt, 1);
    check("lu_dropped", 32'(hz.StallF), 0);
    hz.result_srcE = 2'b01; hz.rdE = 0; hz.rs2D = 0;
    #1 check("lu_rd0_nostall", 32'(hz.StallF), 0);
    cyc();
    clear_in();

    // Branch over load-use
    hz.result_srcE = 2'b01; hz.rdE = 7; hz.rs1D = 7; hz.pc_srcE = 1;
    #1 check("br_lu_strobes {FD,FE,SF}", 32'({hz.FlushD, hz.FlushE, hz.StallF}), 32'h6);
    cyc();
    clear_in();
    #1 check("br_flush_cnt", hz.flush_cnt, 1);
    check("br_lu_cnt_same", hz.lu_stall_cnt, 1);

    // Memory wait: three stalled cycles, branch held off
    for (int i = 0; i < 3; i++) begin
      hz.mem_reqM = 1; hz.mem_ready = 0; hz.pc_srcE = 1;
      #1 check("mw_stalls", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'h1f);
      check("mw_no_flush", 32'({hz.FlushD, hz.FlushE}), 0);
      cyc();
    end
    hz.pc_srcE = 0; hz.mem_ready = 1;
    #1 check("mw_release", 32'({hz.StallF, hz.StallM, hz.FlushW}), 0);
    cyc();
    clear_in();
    #1 check("mw_cnt_3", hz.mem_wait_cnt, 3);
    check("mw_flush_cnt_same", hz.flush_cnt, 1);
    hz.mem_reqM = 1; hz.mem_ready = 1;
    #1 check("zero_wait_nostall", 32'(hz.StallF), 0);
    cyc();
    clear_in();

    // Watchdog: timeout after the 4th WAIT cycle, stall kept
    for (int i = 1; i <= 10; i++) begin
      hz.mem_reqM = 1; hz.mem_ready = 0;
      #1 check("wd_timeout", 32'(hz.mem_timeout), (i >= 6) ? 1 : 0);
      check("wd_stall", 32'(hz.StallE), 1);
      cyc();
    end
    hz.mem_ready = 1;
    #1 check("wd_release", 32'(hz.StallF), 0);
    cyc();
    clear_in();
    #1 check("wd_sticky", 32'(hz.mem_timeout), 1);
    check("wd_mw_cnt", hz.mem_wait_cnt, 13);

    // Reset in the middle of a wait
    hz.mem_reqM = 1;
    cyc();
    cyc();
    reset = 1'b0;
    #1 check("rst_mid_outputs", 32'({hz.StallF, hz.StallE, hz.FlushW}), 0);
    cyc();
    reset = 1'b1;
    #1 check("rst_mid_cnts", hz.lu_stall_cnt | hz.flush_cnt | hz.mem_wait_cnt, 0);
    check("rst_mid_timeout", 32'(hz.mem_timeout), 0);
    check("rst_mid_restall", 32'(hz.StallF), 1);
    cyc();
    hz.mem_ready = 1;
    cyc();
    clear_in();
    #1 check("rst_mid_mw_cnt", hz.mem_wait_cnt, 1);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. Generates the stall/flush strobes that drive the fetch, decode-to-execute, execute-to-memory and memory-to-writeback pipeline registers, plus the execute-stage forwarding selects. It holds a small FSM that freezes the pipeline across multi-cycle data-memory accesses, a wait-timeout watchdog, and three hazard performance counters.

## Interface
- MEM_TIMEOUT, 255: memory-wait cycles after which `mem_timeout` latches.
- CNT_W, 32: performance counter width.

- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset==0 clears all state
- rs1D, rs2D  in  5  source registers of instruction in decode
- rs1E, rs2E, rdE  in  5  sources/destination of instruction in execute
- result_srcE  in  2  result select in execute; 2'b01 = load
- pc_srcE  in  1  taken branch or jump resolved in execute
- rdM, rdW  in  5  destinations in memory / writeback
- reg_writeM, reg_writeW  in  1  register-write enables in memory / writeback
- mem_reqM  in  1  memory stage holds a load/store access
- mem_ready  in  1  data memory completes access this cycle
- forward_aE, forward_bE  out  2  ALU operand select: 00 register file, 10 memory-stage result, 01 writeback result
- StallF, StallD, StallE, StallM  out  1  hold PC / pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register to bubble
- mem_timeout  out  1  sticky watchdog error
- lu_stall_cnt, flush_cnt, mem_wait_cnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational, per operand, shown for A): 10 if reg_writeM && rdM!=0 && rdM==rs1E; else 01 if reg_writeW && rdW!=0 && rdW==rs1E; else 00. Memory stage wins over writeback. B identical with rs2E.
- lu = result_srcE==2'b01 && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- mw = mem_reqM && !mem_ready (memory wait, in either FSM state).
- Priority: mw > pc_srcE > lu.
  - mw: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (a flush must never be issued into a frozen stage; pending pc_srcE/lu re-evaluate after release).
  - else pc_srcE: FlushD=1, FlushE=1, all stalls 0 (branch squashes any load-use bubble).
  - else lu: StallF=1, StallD=1, FlushE=1.
  - else all strobes 0.
- FSM states IDLE, WAIT, tracking the wait for the counters and watchdog only:
  - IDLE -> WAIT when mw; WAIT -> IDLE when mem_ready; WAIT holds otherwise.
  - wait_cycles (8-bit+, saturating) clears on entry to WAIT and increments each WAIT cycle; when it reaches MEM_TIMEOUT, mem_timeout sets and stays 1 until reset. The stall is not released by a timeout.
- Counters, each wrapping at 2^CNT_W: lu_stall_cnt +1 per cycle lu drives a bubble (lu && !pc_srcE && !mw); flush_cnt +1 per cycle pc_srcE flushes (pc_srcE && !mw); mem_wait_cnt +1 per cycle mw.

## Timing
- Strobes and forwarding are combinational from same-cycle inputs; they act at the next rising edge through the pipeline registers.
- Load-use: exactly one bubble per load-use pair (E advances past the load next cycle, lu drops).
- Memory wait: stalls assert in the same cycle mem_reqM rises with mem_ready low; they drop combinationally in the cycle mem_ready=1 so that edge advances the pipeline. Zero-wait access (mem_ready with mem_reqM) produces no stall and no FSM transition.
- Reset (reset==0 at an edge): state=IDLE, wait_cycles=0, mem_timeout=0, all counters 0. While reset==0, all stall/flush outputs and forward selects are driven 0.
- Reset mid-wait: FSM returns to IDLE next edge regardless of mem_ready; counters cleared.
- pc_srcE and lu together: only flush; lu_stall_cnt does not increment.

## Test plan
- Forwarding: rs1E=5, rdM=5, reg_writeM=1, rdW=5, reg_writeW=1 -> forward_aE=10; drop reg_writeM -> 01; rdM=rdW=0 with rs1E=0 -> 00.
- Load-use: result_srcE=01, rdE=7, rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, lu_stall_cnt 0->1; rdE=0 -> no stall.
- Branch over load-use: pc_srcE=1 with lu true -> FlushD=FlushE=1, StallF=0, flush_cnt +1, lu_stall_cnt unchanged.
- Memory wait: mem_reqM=1, mem_ready low 3 cycles then high -> StallF/D/E/M and FlushW high exactly 3 cycles, FlushE=0 throughout even with pc_srcE=1, mem_wait_cnt=3, FSM back to IDLE.
- Watchdog: MEM_TIMEOUT=4, mem_ready held low 10 cycles -> mem_timeout rises after 4th WAIT cycle, stalls persist; then mem_ready=1 -> stalls drop, mem_timeout stays 1.
- Reset mid-wait: reset=0 during WAIT -> next edge state IDLE, all counters 0, mem_timeout 0, outputs 0 while reset low.
